// File: rtl/ball_collision_ctrl.sv
// rtl/ball_collision_ctrl.sv - per-frame ball-ball and cushion velocity resolver for two balls
module ball_collision_ctrl #(
    parameter int BALL_DIAMETER = 32,
    parameter int TABLE_LEFT    = 0,
    parameter int TABLE_RIGHT   = 639,
    parameter int TABLE_TOP     = 0,
    parameter int TABLE_BOTTOM  = 479
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic signed [10:0] posAX,
    input  logic signed [10:0] posAY,
    input  logic signed [10:0] velAX,
    input  logic signed [10:0] velAY,
    input  logic signed [10:0] posBX,
    input  logic signed [10:0] posBY,
    input  logic signed [10:0] velBX,
    input  logic signed [10:0] velBY,
    output logic               velocityWriteEnableA,
    output logic signed [10:0] outvelocityAX,
    output logic signed [10:0] outvelocityAY,
    output logic               velocityWriteEnableB,
    output logic signed [10:0] outvelocityBX,
    output logic signed [10:0] outvelocityBY,
    output logic               hitPulse,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, SAMPLE, DETECT, RESOLVE, WRITE} state_t;

    localparam logic        [23:0] DIAM2 = 24'(BALL_DIAMETER * BALL_DIAMETER);
    localparam logic signed [11:0] X_LO  = 12'(TABLE_LEFT);
    localparam logic signed [11:0] X_HI  = 12'(TABLE_RIGHT - BALL_DIAMETER);
    localparam logic signed [11:0] Y_LO  = 12'(TABLE_TOP);
    localparam logic signed [11:0] Y_HI  = 12'(TABLE_BOTTOM - BALL_DIAMETER);

    state_t state, state_nxt;

    logic signed [10:0] s_pax, s_pay, s_vax, s_vay;
    logic signed [10:0] s_pbx, s_pby, s_vbx, s_vby;
    logic               contact_r;

    logic signed [11:0] dx, dy, dvx, dvy;
    logic signed [23:0] dx_w, dy_w;
    logic signed [24:0] dx_d, dy_d, dvx_d, dvy_d;
    logic        [23:0] dist2;
    logic signed [24:0] dot;
    logic               contact;

    logic signed [10:0] pre_ax, pre_ay, pre_bx, pre_by;
    logic signed [10:0] new_ax, new_ay, new_bx, new_by;
    logic               changed_a, changed_b;

    // Negating -1024 would wrap back to -1024, so clamp to +1023.
    function automatic logic signed [10:0] neg_sat(input logic signed [10:0] v);
        if (v == {1'b1, 10'b0})
            return 11'sh3FF;
        return -v;
    endfunction

    function automatic logic signed [10:0] reflect(input logic signed [10:0] p,
                                                   input logic signed [10:0] v,
                                                   input logic signed [11:0] lo,
                                                   input logic signed [11:0] hi);
        logic signed [11:0] pe;
        pe = {p[10], p};
        if (pe < lo && v[10])
            return neg_sat(v);
        if (pe > hi && !v[10] && v != '0)
            return neg_sat(v);
        return v;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (startOfFrame) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = DETECT;
            DETECT:  state_nxt = RESOLVE;
            RESOLVE: state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s_pax <= '0; s_pay <= '0; s_vax <= '0; s_vay <= '0;
            s_pbx <= '0; s_pby <= '0; s_vbx <= '0; s_vby <= '0;
        end else if (state == SAMPLE) begin
            s_pax <= posAX; s_pay <= posAY; s_vax <= velAX; s_vay <= velAY;
            s_pbx <= posBX; s_pby <= posBY; s_vbx <= velBX; s_vby <= velBY;
        end
    end

    always_comb begin
        dx    = {s_pbx[10], s_pbx} - {s_pax[10], s_pax};
        dy    = {s_pby[10], s_pby} - {s_pay[10], s_pay};
        dvx   = {s_vbx[10], s_vbx} - {s_vax[10], s_vax};
        dvy   = {s_vby[10], s_vby} - {s_vay[10], s_vay};
        dx_w  = {{12{dx[11]}}, dx};
        dy_w  = {{12{dy[11]}}, dy};
        dx_d  = {{13{dx[11]}}, dx};
        dy_d  = {{13{dy[11]}}, dy};
        dvx_d = {{13{dvx[11]}}, dvx};
        dvy_d = {{13{dvy[11]}}, dvy};
        dist2 = dx_w * dx_w + dy_w * dy_w;
        dot   = dx_d * dvx_d + dy_d * dvy_d;
        // Overlapping but moving apart must not swap again next frame.
        contact = (dist2 <= DIAM2) && dot[24];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            contact_r <= 1'b0;
        else if (state == DETECT)
            contact_r <= contact;
    end

    always_comb begin
        pre_ax = contact_r ? s_vbx : s_vax;
        pre_ay = contact_r ? s_vby : s_vay;
        pre_bx = contact_r ? s_vax : s_vbx;
        pre_by = contact_r ? s_vay : s_vby;
        new_ax = reflect(s_pax, pre_ax, X_LO, X_HI);
        new_ay = reflect(s_pay, pre_ay, Y_LO, Y_HI);
        new_bx = reflect(s_pbx, pre_bx, X_LO, X_HI);
        new_by = reflect(s_pby, pre_by, Y_LO, Y_HI);
        changed_a = {new_ax, new_ay} != {s_vax, s_vay};
        changed_b = {new_bx, new_by} != {s_vbx, s_vby};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            velocityWriteEnableA <= 1'b0;
            velocityWriteEnableB <= 1'b0;
            hitPulse             <= 1'b0;
            outvelocityAX        <= '0;
            outvelocityAY        <= '0;
            outvelocityBX        <= '0;
            outvelocityBY        <= '0;
        end else begin
            velocityWriteEnableA <= 1'b0;
            velocityWriteEnableB <= 1'b0;
            hitPulse             <= 1'b0;
            if (state == RESOLVE) begin
                velocityWriteEnableA <= changed_a;
                velocityWriteEnableB <= changed_b;
                hitPulse             <= contact_r;
                if (changed_a) begin
                    outvelocityAX <= new_ax;
                    outvelocityAY <= new_ay;
                end
                if (changed_b) begin
                    outvelocityBX <= new_bx;
                    outvelocityBY <= new_by;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ball_collision_ctrl.sv
// tb/tb_ball_collision_ctrl.sv - directed scoreboard bench for ball_collision_ctrl
module tb_ball_collision_ctrl;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic signed [10:0] posAX, posAY, velAX, velAY;
    logic signed [10:0] posBX, posBY, velBX, velBY;
    logic               velocityWriteEnableA, velocityWriteEnableB;
    logic signed [10:0] outvelocityAX, outvelocityAY, outvelocityBX, outvelocityBY;
    logic               hitPulse, busy;

    typedef struct {
        logic               en_a;
        logic               en_b;
        logic               hit;
        logic signed [10:0] ax, ay, bx, by;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    ball_collision_ctrl dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .posAX                (posAX),
        .posAY                (posAY),
        .velAX                (velAX),
        .velAY                (velAY),
        .posBX                (posBX),
        .posBY                (posBY),
        .velBX                (velBX),
        .velBY                (velBY),
        .velocityWriteEnableA (velocityWriteEnableA),
        .outvelocityAX        (outvelocityAX),
        .outvelocityAY        (outvelocityAY),
        .velocityWriteEnableB (velocityWriteEnableB),
        .outvelocityBX        (outvelocityBX),
        .outvelocityBY        (outvelocityBY),
        .hitPulse             (hitPulse),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input string field,
                         input logic signed [31:0] obs, input logic signed [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s/%s: observed %0d expected %0d", tag, field, obs, exp);
        end
    endtask

    task automatic set_balls(input int pax, pay, vax, vay, pbx, pby, vbx, vby);
        posAX = 11'(pax); posAY = 11'(pay); velAX = 11'(vax); velAY = 11'(vay);
        posBX = 11'(pbx); posBY = 11'(pby); velBX = 11'(vbx); velBY = 11'(vby);
    endtask

    task automatic push_exp(input logic ea, eb, h, input int ax, ay, bx, by);
        exp_t e;
        e.en_a = ea; e.en_b = eb; e.hit = h;
        e.ax = 11'(ax); e.ay = 11'(ay); e.bx = 11'(bx); e.by = 11'(by);
        exp_q.push_back(e);
    endtask

    // Pulses startOfFrame, watches 7 cycles, then scores against the queued expectation.
    task automatic run_frame(input string tag, input logic extra);
        int   cnt_a, cnt_b, cnt_h, first_a, first_b, first_h;
        exp_t e;
        cnt_a = 0; cnt_b = 0; cnt_h = 0; first_a = 0; first_b = 0; first_h = 0;
        @(negedge clk);
        startOfFrame = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) startOfFrame = 1'b0;
            if (extra && k == 2) startOfFrame = 1'b1;
            if (k == 3) startOfFrame = 1'b0;
            if (k == 2) check(tag, "busy_mid", busy, 1);
            if (velocityWriteEnableA) begin cnt_a++; if (first_a == 0) first_a = k; end
            if (velocityWriteEnableB) begin cnt_b++; if (first_b == 0) first_b = k; end
            if (hitPulse)             begin cnt_h++; if (first_h == 0) first_h = k; end
        end
        if (exp_q.size() == 0) begin
            check(tag, "queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check(tag, "enA_count", cnt_a, e.en_a ? 1 : 0);
            check(tag, "enB_count", cnt_b, e.en_b ? 1 : 0);
            check(tag, "hit_count", cnt_h, e.hit ? 1 : 0);
            check(tag, "enA_cycle", first_a, e.en_a ? 4 : 0);
            check(tag, "enB_cycle", first_b, e.en_b ? 4 : 0);
            check(tag, "hit_cycle", first_h, e.hit ? 4 : 0);
            check(tag, "outAX", outvelocityAX, e.ax);
            check(tag, "outAY", outvelocityAY, e.ay);
            check(tag, "outBX", outvelocityBX, e.bx);
            check(tag, "outBY", outvelocityBY, e.by);
            check(tag, "busy_end", busy, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, "enA", velocityWriteEnableA, 0);
        check(tag, "enB", velocityWriteEnableB, 0);
        check(tag, "hit", hitPulse, 0);
        check(tag, "busy", busy, 0);
        check(tag, "outAX", outvelocityAX, 0);
        check(tag, "outAY", outvelocityAY, 0);
        check(tag, "outBX", outvelocityBX, 0);
        check(tag, "outBY", outvelocityBY, 0);
    endtask

    initial begin
        int strobes;
        resetN = 1'b0;
        startOfFrame = 1'b0;
        set_balls(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        resetN = 1'b1;
        @(negedge clk);

        set_balls(100, 100, 8, 0, 120, 100, 0, 0);
        push_exp(1, 1, 1, 0, 0, 8, 0);
        run_frame("head_on", 1'b0);

        set_balls(100, 100, -8, 0, 120, 100, 0, 0);
        push_exp(0, 0, 0, 0, 0, 8, 0);
        run_frame("separating", 1'b0);

        set_balls(-2, 50, -5, 3, 300, 300, 0, 0);
        push_exp(1, 0, 0, 5, 3, 8, 0);
        run_frame("left_wall", 1'b0);

        set_balls(100, 460, 2, 7, 300, 300, 0, 0);
        push_exp(1, 0, 0, 2, -7, 8, 0);
        run_frame("bottom_wall", 1'b0);

        set_balls(100, 460, 2, -7, 300, 300, 0, 0);
        push_exp(0, 0, 0, 2, -7, 8, 0);
        run_frame("bottom_leaving", 1'b0);

        set_balls(700, 10, 1023, 0, 300, 300, 0, 0);
        push_exp(1, 0, 0, -1023, 0, 8, 0);
        run_frame("right_max", 1'b0);

        set_balls(-5, 10, -1024, 0, 300, 300, 0, 0);
        push_exp(1, 0, 0, 1023, 0, 8, 0);
        run_frame("left_sat", 1'b0);

        set_balls(100, 100, 0, 0, 110, 100, 0, 0);
        push_exp(0, 0, 0, 1023, 0, 8, 0);
        run_frame("rest_overlap", 1'b0);

        set_balls(200, 200, 0, 3, 200, 220, 0, -3);
        push_exp(1, 1, 1, 0, -3, 0, 3);
        run_frame("extra_sof", 1'b1);

        // Reset asserted while the FSM sits in DETECT.
        set_balls(100, 100, 8, 0, 120, 100, 0, 0);
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
        check("mid_reset", "busy_before", busy, 1);
        resetN = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        resetN = 1'b1;
        strobes = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (velocityWriteEnableA || velocityWriteEnableB || hitPulse) strobes++;
        end
        check("mid_reset", "strobes_after", strobes, 0);
        check_all_zero("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
